// File: rtl/branch_update_queue_if.sv
// Fetch/execute/predictor-side signal bundle for branch_update_queue.
// The queue sits on the slave side; fetch, execute and the predictor sit on the master side.
interface branch_update_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 32
);
    localparam int unsigned TAG_W = $clog2(DEPTH);

    logic             flush;
    logic             alloc_valid;
    logic [PC_W-1:0]  alloc_pc;
    logic             alloc_pred;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             resolve_taken;
    logic             update_en;
    logic [PC_W-1:0]  update_pc;
    logic             actual_taken;
    logic             update_mispred;
    logic [TAG_W:0]   count;

    modport slave (
        input  flush, alloc_valid, alloc_pc, alloc_pred,
        input  resolve_valid, resolve_tag, resolve_taken,
        output alloc_ready, alloc_tag,
        output update_en, update_pc, actual_taken, update_mispred, count
    );

    modport master (
        output flush, alloc_valid, alloc_pc, alloc_pred,
        output resolve_valid, resolve_tag, resolve_taken,
        input  alloc_ready, alloc_tag,
        input  update_en, update_pc, actual_taken, update_mispred, count
    );
endinterface

// File: rtl/branch_update_queue.sv
// In-order retirement queue for predicted branches: fetch allocates, execute resolves by tag
// in any order, and resolved entries retire from the head as one predictor update per cycle.
module branch_update_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 32
) (
    input logic                  clk,
    input logic                  reset,
    branch_update_queue_if.slave bus
);
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam logic [TAG_W:0] FullCount = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] resolved_q, resolved_d;
    logic [DEPTH-1:0] pred_q, pred_d;
    logic [DEPTH-1:0] taken_q, taken_d;
    logic [PC_W-1:0]  pc_q [DEPTH];
    logic [PC_W-1:0]  pc_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             update_en_q, update_en_d;
    logic [PC_W-1:0]  update_pc_q, update_pc_d;
    logic             actual_taken_q, actual_taken_d;
    logic             update_mispred_q, update_mispred_d;

    logic alloc_fire;
    logic resolve_fire;
    logic retire_fire;

    // All fire conditions look only at registered state, so the head cannot retire on the
    // same edge that resolves it.
    always_comb begin
        alloc_fire   = bus.alloc_valid && (count_q != FullCount);
        retire_fire  = valid_q[head_q] && resolved_q[head_q];
        resolve_fire = bus.resolve_valid && valid_q[bus.resolve_tag]
                       && !resolved_q[bus.resolve_tag];

        valid_d          = valid_q;
        resolved_d       = resolved_q;
        pred_d           = pred_q;
        taken_d          = taken_q;
        pc_d             = pc_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        update_en_d      = 1'b0;
        update_pc_d      = update_pc_q;
        actual_taken_d   = actual_taken_q;
        update_mispred_d = update_mispred_q;

        if (bus.flush) begin
            valid_d    = '0;
            resolved_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (retire_fire) begin
                update_en_d         = 1'b1;
                update_pc_d         = pc_q[head_q];
                actual_taken_d      = taken_q[head_q];
                update_mispred_d    = pred_q[head_q] ^ taken_q[head_q];
                valid_d[head_q]     = 1'b0;
                resolved_d[head_q]  = 1'b0;
                head_d              = head_q + TAG_W'(1);
            end
            if (resolve_fire) begin
                resolved_d[bus.resolve_tag] = 1'b1;
                taken_d[bus.resolve_tag]    = bus.resolve_taken;
            end
            // An allocable tail slot is always invalid, so it never collides with a resolve.
            if (alloc_fire) begin
                valid_d[tail_q]    = 1'b1;
                resolved_d[tail_q] = 1'b0;
                pc_d[tail_q]       = bus.alloc_pc;
                pred_d[tail_q]     = bus.alloc_pred;
                tail_d             = tail_q + TAG_W'(1);
            end
            count_d = count_q + (TAG_W + 1)'(alloc_fire) - (TAG_W + 1)'(retire_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q          <= '0;
            resolved_q       <= '0;
            pred_q           <= '0;
            taken_q          <= '0;
            pc_q             <= '{default: '0};
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            update_en_q      <= 1'b0;
            update_pc_q      <= '0;
            actual_taken_q   <= 1'b0;
            update_mispred_q <= 1'b0;
        end else begin
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            pred_q           <= pred_d;
            taken_q          <= taken_d;
            pc_q             <= pc_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            update_en_q      <= update_en_d;
            update_pc_q      <= update_pc_d;
            actual_taken_q   <= actual_taken_d;
            update_mispred_q <= update_mispred_d;
        end
    end

    assign bus.alloc_ready    = (count_q != FullCount);
    assign bus.alloc_tag      = tail_q;
    assign bus.count          = count_q;
    assign bus.update_en      = update_en_q;
    assign bus.update_pc      = update_pc_q;
    assign bus.actual_taken   = actual_taken_q;
    assign bus.update_mispred = update_mispred_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: a program-order list model predicts each retirement,
// and a separate monitor matches every update_en pulse against the expected queue.
module tb_branch_update_queue;
    localparam int DEPTH = 8;
    localparam int PC_W  = 32;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic        resolved;
        logic        taken;
        int          tag;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        mispred;
        longint      cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset = 1'b0;
    longint cyc = 0;
    int     total = 0;
    int     bad = 0;

    ent_t        m_q[$];
    exp_t        exp_q[$];
    int          m_tail = 0;
    logic [31:0] m_last_pc = '0;
    logic        m_last_taken = 1'b0;
    logic        m_last_mis = 1'b0;

    branch_update_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    branch_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each update_en pulse must match the oldest expected retirement, in its cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_update", 64'd0, 64'd1);
                void'(exp_q.pop_front());
            end
            if (bus.update_en) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    chk("spurious_update", 64'd1, 64'd0);
                end else begin
                    chk("update_pc", bus.update_pc, exp_q[0].pc);
                    chk("actual_taken", bus.actual_taken, exp_q[0].taken);
                    chk("update_mispred", bus.update_mispred, exp_q[0].mispred);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock: check visible state against the model, drive inputs, advance the model.
    task automatic cycle(input logic fl, input logic av, input logic [31:0] apc,
                         input logic ap, input logic rv, input logic [2:0] rt,
                         input logic rk);
        int  sz;
        bit  ret;
        @(negedge clk);
        chk("count", bus.count, m_q.size());
        chk("alloc_ready", bus.alloc_ready, m_q.size() != DEPTH);
        chk("alloc_tag", bus.alloc_tag, m_tail);
        chk("hold_pc", bus.update_pc, m_last_pc);
        chk("hold_taken", bus.actual_taken, m_last_taken);
        chk("hold_mispred", bus.update_mispred, m_last_mis);
        bus.flush         = fl;
        bus.alloc_valid   = av;
        bus.alloc_pc      = apc;
        bus.alloc_pred    = ap;
        bus.resolve_valid = rv;
        bus.resolve_tag   = rt;
        bus.resolve_taken = rk;
        if (fl) begin
            m_q.delete();
            m_tail = 0;
        end else begin
            sz  = m_q.size();
            ret = (sz > 0) && m_q[0].resolved;
            if (rv) begin
                foreach (m_q[i]) begin
                    if (m_q[i].tag == int'(rt) && !m_q[i].resolved) begin
                        m_q[i].resolved = 1'b1;
                        m_q[i].taken    = rk;
                    end
                end
            end
            if (ret) begin
                m_last_pc    = m_q[0].pc;
                m_last_taken = m_q[0].taken;
                m_last_mis   = m_q[0].pred != m_q[0].taken;
                exp_q.push_back('{m_last_pc, m_last_taken, m_last_mis, cyc + 1});
                void'(m_q.pop_front());
            end
            if (av && sz < DEPTH) begin
                m_q.push_back('{apc, ap, 1'b0, 1'b0, m_tail});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 0, 0, 3'd0, 0);
    endtask

    task automatic alloc(input logic [31:0] pc, input logic pred);
        cycle(0, 1, pc, pred, 0, 3'd0, 0);
    endtask

    task automatic resolve(input logic [2:0] tag, input logic taken);
        cycle(0, 0, 32'h0, 0, 1, tag, taken);
    endtask

    initial begin
        bus.flush = 0; bus.alloc_valid = 0; bus.alloc_pc = '0; bus.alloc_pred = 0;
        bus.resolve_valid = 0; bus.resolve_tag = '0; bus.resolve_taken = 0;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.alloc_ready, 1);
        chk("rst_tag", bus.alloc_tag, 0);
        chk("rst_update_en", bus.update_en, 0);
        chk("rst_update_pc", bus.update_pc, 0);
        chk("rst_actual_taken", bus.actual_taken, 0);
        chk("rst_mispred", bus.update_mispred, 0);

        // Single mispredicted branch.
        alloc(32'h100, 1);
        resolve(3'd0, 0);
        idle(3);

        // Fill, then a dropped 9th alloc.
        for (int i = 0; i < 9; i++) alloc(32'h200 + 32'(i * 4), i[0]);
        idle(1);
        // Drain in order with out-of-order resolves.
        for (int i = 7; i >= 0; i--) resolve(3'(i), i[1]);
        idle(10);

        // Three entries resolved 2,1,0.
        for (int i = 0; i < 3; i++) alloc(32'h300 + 32'(i * 4), 1);
        resolve(3'(m_tail - 1), 1);
        resolve(3'(m_tail - 2), 0);
        idle(2);
        resolve(3'(m_tail - 3), 1);
        idle(5);

        // Flush with partial resolution and a same-cycle alloc; old tag1 resolve ignored.
        for (int i = 0; i < 4; i++) alloc(32'h400 + 32'(i * 4), 0);
        resolve(3'(m_tail - 3), 1);
        resolve(3'(m_tail - 2), 1);
        cycle(1, 1, 32'h4F0, 1, 0, 3'd0, 0);
        resolve(3'd1, 1);
        idle(4);

        // Full queue with resolved head and alloc held: refused, then accepted at tag 0.
        for (int i = 0; i < 8; i++) alloc(32'h500 + 32'(i * 4), 1);
        resolve(3'd0, 1);
        alloc(32'h600, 0);
        alloc(32'h600, 0);
        alloc(32'h600, 0);
        chk("wrap_count", bus.count, 8);
        for (int i = 1; i < 8; i++) resolve(3'(i), 0);
        resolve(3'd0, 1);
        idle(12);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic       fl, av, rv, rk, ap;
            logic [2:0] rt;
            fl = ($urandom_range(0, 59) == 0);
            av = ($urandom_range(0, 9) < 6);
            ap = 1'(($urandom() >> 3) & 1);
            rv = ($urandom_range(0, 1) == 1);
            rk = 1'(($urandom() >> 5) & 1);
            rt = 3'($urandom_range(0, 7));
            if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
                rt = 3'(m_q[$urandom_range(0, m_q.size() - 1)].tag);
            cycle(fl, av, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ap, rv, rt, rk);
        end
        // Resolve everything left and drain.
        for (int k = 0; k < DEPTH; k++) resolve(3'(k), 1);
        idle(DEPTH + 4);
        chk("drain_count", bus.count, 0);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
